// File: rtl/value_storage_pkg.sv
// Shared definitions for the ADC value store: Wishbone word map, STATUS layout,
// stream FSM states and STREAM command codes.
package value_storage_pkg;

  localparam logic [1:0] REGION_LATEST = 2'd0;
  localparam logic [1:0] REGION_MIN    = 2'd1;
  localparam logic [1:0] REGION_MAX    = 2'd2;
  localparam logic [1:0] REGION_CTRL   = 2'd3;

  localparam logic [5:0] CTRL_STREAM = 6'h00;
  localparam logic [5:0] CTRL_STATUS = 6'h01;
  localparam logic [5:0] CTRL_CLEAR  = 6'h02;
  localparam logic [5:0] CTRL_ENABLE = 6'h03;  // 16 channels per word, 0x0C3 upward

  localparam int STATUS_OVERRUN_BIT = 15;
  localparam int STATUS_FULL_BIT    = 14;
  localparam int STATUS_STATE_LSB   = 12;

  localparam logic [15:0] STREAM_CMD_START = 16'h0000;
  localparam logic [15:0] STREAM_CMD_STOP  = 16'hFFFF;
  localparam logic [15:0] STREAM_END_WORD  = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LAST   = 2'd2
  } stream_state_t;

  function automatic logic [11:0] sat_level(input logic [15:0] lvl);
    return (lvl > 16'h0FFF) ? 12'hFFF : lvl[11:0];
  endfunction

endpackage

// File: rtl/value_stream_ctrl.sv
// Ring-buffer stream reader: walks a snapshot of the ring oldest-first and
// flags an overrun when the writer catches up with unread data.
module value_stream_ctrl
  import value_storage_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 12,
  parameter int RAM_AW       = 13
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    rd,
  input  logic                    status_rd,
  input  logic                    wr_en,
  input  logic [RAM_AW-1:0]       wptr,
  input  logic                    full,
  input  logic [RAM_AW:0]         level,
  input  logic [SAMPLE_WIDTH-1:0] ram_rdata,
  output logic [RAM_AW-1:0]       ram_raddr,
  output logic [15:0]             rd_data,
  output logic [1:0]              state,
  output logic                    overrun
);

  stream_state_t     state_reg, state_next;
  logic [RAM_AW-1:0] rptr_reg, rptr_next;
  logic [RAM_AW:0]   count_reg, count_next;
  logic              overrun_reg, overrun_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      rptr_reg    <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rptr_reg    <= rptr_next;
      count_reg   <= count_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rptr_next    = rptr_reg;
    count_next   = count_reg;
    overrun_next = overrun_reg & ~status_rd;
    rd_data      = STREAM_END_WORD;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_ACTIVE;
          rptr_next  = full ? wptr : '0;
          count_next = level;
        end
      end
      ST_ACTIVE: begin
        if (rd) begin
          if (count_reg != '0) begin
            rd_data    = 16'(ram_rdata);
            rptr_next  = rptr_reg + 1'b1;
            count_next = count_reg - 1'b1;
          end else begin
            state_next = ST_LAST;
          end
        end
        // Writer reaching the oldest unread slot means the snapshot is corrupt.
        if (wr_en && (wptr == rptr_reg) && (count_reg != '0)) begin
          overrun_next = 1'b1;
          state_next   = ST_LAST;
        end
      end
      default: ;
    endcase
    if (stop) state_next = ST_IDLE;
  end

  assign ram_raddr = rptr_reg;
  assign state     = state_reg;
  assign overrun   = overrun_reg;

endmodule

// File: rtl/value_storage_v2.sv
// Per-channel latest/min/max ADC value store with a Wishbone register window
// and a sample ring buffer that can be streamed back oldest-first.
module value_storage_v2
  import value_storage_pkg::*;
#(
  parameter int NUM_CHANNELS = 32,
  parameter int SAMPLE_WIDTH = 12,
  parameter int RAM_AW       = 13,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [15:0]             wb_adr_i,
  input  logic [15:0]             wb_dat_i,
  output logic [15:0]             wb_dat_o,
  output logic                    wb_ack_o,
  input  logic                    adc_strb,
  input  logic [CH_W-1:0]         adc_channel,
  input  logic [SAMPLE_WIDTH-1:0] adc_result,
  output logic                    ram_wen,
  output logic [RAM_AW-1:0]       ram_waddr,
  output logic [SAMPLE_WIDTH-1:0] ram_wdata,
  output logic [RAM_AW-1:0]       ram_raddr,
  input  logic [SAMPLE_WIDTH-1:0] ram_rdata
);

  // Assert asynchronously, release two clocks later.
  logic [1:0] rst_pipe;
  logic       rst_n;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) rst_pipe <= 2'b00;
    else            rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  logic [SAMPLE_WIDTH-1:0] latest_reg [NUM_CHANNELS];
  logic [SAMPLE_WIDTH-1:0] min_reg    [NUM_CHANNELS];
  logic [SAMPLE_WIDTH-1:0] max_reg    [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] enable_reg;
  logic [RAM_AW-1:0]       wptr_reg;
  logic                    full_reg, ack_reg, pend_reg;
  logic [15:0]             dat_reg;

  logic        req, rd, wr, in_map, ctrl_sel, stream_sel;
  logic        start, stop, stream_rd, status_rd, clear;
  logic [1:0]  region;
  logic [5:0]  idx;
  logic [15:0] reg_rdata, status_word, stream_data;
  logic [1:0]  stream_state;
  logic        overrun;
  logic [RAM_AW:0] level;
  logic [NUM_CHANNELS-1:0] hit;
  logic        sample_wr;

  assign req        = wb_cyc_i & wb_stb_i & ~ack_reg & ~pend_reg;
  assign rd         = req & ~wb_we_i;
  assign wr         = req & wb_we_i;
  assign in_map     = (wb_adr_i[15:8] == 8'h00);
  assign region     = wb_adr_i[7:6];
  assign idx        = wb_adr_i[5:0];
  assign ctrl_sel   = in_map && (region == REGION_CTRL);
  assign stream_sel = ctrl_sel && (idx == CTRL_STREAM);
  assign start      = wr && stream_sel && (wb_dat_i == STREAM_CMD_START);
  assign stop       = wr && stream_sel && (wb_dat_i == STREAM_CMD_STOP);
  assign stream_rd  = rd && stream_sel;
  assign status_rd  = rd && ctrl_sel && (idx == CTRL_STATUS);
  assign clear      = wr && ctrl_sel && (idx == CTRL_CLEAR);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_hit
      assign hit[gi] = rst_n && adc_strb && enable_reg[gi] && (adc_channel == CH_W'(gi));
    end
  endgenerate

  assign sample_wr = |hit;
  assign ram_wen   = sample_wr;
  assign ram_waddr = wptr_reg;
  assign ram_wdata = sample_wr ? adc_result : '0;
  assign level     = full_reg ? {1'b1, {RAM_AW{1'b0}}} : {1'b0, wptr_reg};

  always_comb begin
    status_word                             = '0;
    status_word[STATUS_OVERRUN_BIT]         = overrun;
    status_word[STATUS_FULL_BIT]            = full_reg;
    status_word[STATUS_STATE_LSB +: 2]      = stream_state;
    status_word[11:0]                       = sat_level(16'(level));
  end

  always_comb begin
    reg_rdata = '0;
    if (in_map) begin
      case (region)
        REGION_LATEST: for (int i = 0; i < NUM_CHANNELS; i++)
                         if (idx == 6'(i)) reg_rdata = 16'(latest_reg[i]);
        REGION_MIN:    for (int i = 0; i < NUM_CHANNELS; i++)
                         if (idx == 6'(i)) reg_rdata = 16'(min_reg[i]);
        REGION_MAX:    for (int i = 0; i < NUM_CHANNELS; i++)
                         if (idx == 6'(i)) reg_rdata = 16'(max_reg[i]);
        default: begin
          if (idx == CTRL_STATUS) reg_rdata = status_word;
          for (int i = 0; i < NUM_CHANNELS; i++)
            if (idx == CTRL_ENABLE + 6'(i / 16)) reg_rdata[i % 16] = enable_reg[i];
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        latest_reg[i] <= '0;
        min_reg[i]    <= '1;
        max_reg[i]    <= '0;
      end
      enable_reg <= '1;
      wptr_reg   <= '0;
      full_reg   <= 1'b0;
      ack_reg    <= 1'b0;
      pend_reg   <= 1'b0;
      dat_reg    <= '0;
    end else begin
      ack_reg  <= 1'b0;
      dat_reg  <= '0;
      pend_reg <= stream_rd;
      // STREAM reads wait one extra cycle for the RAM read data.
      if (req && !stream_rd) begin
        ack_reg <= 1'b1;
        dat_reg <= rd ? reg_rdata : 16'h0000;
      end
      if (pend_reg) begin
        ack_reg <= 1'b1;
        dat_reg <= stream_data;
      end
      if (sample_wr) begin
        wptr_reg <= wptr_reg + 1'b1;
        if (wptr_reg == '1) full_reg <= 1'b1;
      end
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (hit[i]) begin
          latest_reg[i] <= adc_result;
          min_reg[i]    <= (clear || adc_result < min_reg[i]) ? adc_result : min_reg[i];
          max_reg[i]    <= (clear || adc_result > max_reg[i]) ? adc_result : max_reg[i];
        end else if (clear) begin
          min_reg[i] <= '1;
          max_reg[i] <= '0;
        end
        if (wr && ctrl_sel && (idx == CTRL_ENABLE + 6'(i / 16)))
          enable_reg[i] <= wb_dat_i[i % 16];
      end
    end
  end

  value_stream_ctrl #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .RAM_AW      (RAM_AW)
  ) u_stream (
    .clk      (wb_clk_i),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .rd       (pend_reg),
    .status_rd(status_rd),
    .wr_en    (sample_wr),
    .wptr     (wptr_reg),
    .full     (full_reg),
    .level    (level),
    .ram_rdata(ram_rdata),
    .ram_raddr(ram_raddr),
    .rd_data  (stream_data),
    .state    (stream_state),
    .overrun  (overrun)
  );

  assign wb_ack_o = ack_reg;
  assign wb_dat_o = dat_reg;

endmodule

// File: doc/value_storage_v2.md
VALUE_STORAGE_V2 -- requirements
Module: value_storage_v2

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 32, number of ADC channels (1..64).
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 12, ADC result width (1..15).
REQ-003 SHALL have parameter RAM_AW, default 13, ring RAM address width; depth = 2**RAM_AW.
REQ-004 SHALL have ports: wb_clk_i in 1, sole clock; wb_rst_ni in 1, asynchronous active-low reset.
REQ-005 SHALL have Wishbone slave ports: wb_cyc_i, wb_stb_i, wb_we_i in 1; wb_adr_i in 16; wb_dat_i in 16; wb_dat_o out 16; wb_ack_o out 1.
REQ-006 SHALL have ADC ports: adc_strb in 1, sample valid; adc_channel in clog2(NUM_CHANNELS); adc_result in SAMPLE_WIDTH.
REQ-007 SHALL have ring RAM ports: ram_wen out 1; ram_waddr out RAM_AW; ram_wdata out SAMPLE_WIDTH; ram_raddr out RAM_AW; ram_rdata in SAMPLE_WIDTH, valid one cycle after ram_raddr.

Function
REQ-008 Word map: 0x000+ch latest, 0x040+ch running min, 0x080+ch running max, 0x0C0 STREAM, 0x0C1 STATUS, 0x0C2 CLEAR, 0x0C3 ENABLE (low NUM_CHANNELS bits, rest ignored; channels >=16 via 0x0C4 high half).
REQ-009 Reads return value zero-extended to 16 bits; unmapped or ch>=NUM_CHANNELS reads return 0x0000 and are acked.
REQ-010 Register reads/writes: wb_ack_o one cycle after cyc&stb, single-cycle pulse; STREAM reads ack two cycles after (RAM latency).
REQ-011 On adc_strb with channel enabled: latest[ch]<=result; min[ch]<=min(min,result); max[ch]<=max(max,result); same cycle ram_wen=1, ram_waddr=wptr, ram_wdata=result, wptr<=wptr+1 mod depth.
REQ-012 Disabled channel strobe: no register, RAM or pointer update.
REQ-013 Ring full flag set once wptr wraps; level = full ? depth : wptr.
REQ-014 Stream FSM states IDLE, ACTIVE, LAST; write 0x0000 to STREAM in IDLE -> ACTIVE, capture end=wptr, rptr = full ? wptr : 0, count=level.
REQ-015 ACTIVE read: returns {1'b0, zero pad, ram_rdata}, rptr++, count--; read when count reaches 0 returns 0x8000 and enters LAST.
REQ-016 LAST: reads return 0x8000; write 0xFFFF to STREAM -> IDLE from any state; IDLE reads return 0x8000.
REQ-017 Writes continue during ACTIVE; if wptr passes rptr (overrun), next read returns 0x8000, STATUS.overrun set, state LAST.
REQ-018 STATUS read: bit15 overrun, bit14 full, bits13..12 FSM state, bits11..0 level saturated to 0xFFF; read clears overrun.
REQ-019 CLEAR write (any data): min[*]<=all-ones, max[*]<=0; strobe same cycle wins: min=max=result for that channel.
REQ-020 Simultaneous WB access and adc_strb SHALL both complete the same cycle; latest read in that cycle returns the pre-update value.
REQ-021 Other STREAM write values ignored, acked.

Reset
REQ-022 On wb_rst_ni low: wb_ack_o=0, wb_dat_o=0, ram_wen=0, ram_waddr=0, ram_raddr=0, ram_wdata=0.
REQ-023 Reset: latest=0, min=all-ones, max=0, ENABLE=all-ones, wptr=0, full=0, overrun=0, FSM IDLE; mid-stream reset aborts stream.
REQ-024 Reset deassertion SHALL be synchronised internally before use.

Structure
REQ-025 Shared package value_storage_pkg: address map constants, STATUS bit positions, FSM state enum, STREAM command codes.
REQ-026 Stream engine SHALL be sub-module value_stream_ctrl (FSM, rptr, count, overrun); registers and WB decode in top.

Verification
REQ-027 Defaults, 32 channels strobed result=0x400+ch -> read 0x000..0x01F returns 0x0400..0x041F.
REQ-028 Ch 5 fed 0x100, 0x050, 0x300 -> min 0x045 reads 0x0050, max 0x085 reads 0x0300; CLEAR then 0x200 -> both 0x0200.
REQ-029 RAM_AW=8, 300 strobes, stream start -> 256 reads oldest-first (0x400+(44+i)%32), 257th read 0x8000, write 0xFFFF -> STATUS state IDLE.
REQ-030 ENABLE=0x00000001 -> only ch 0 updates; ram_wen asserted only for ch 0 strobes.
REQ-031 RAM_AW=4, strobe every cycle during stream -> overrun: 0x8000 early, STATUS bit15=1, cleared on second read.
REQ-032 Assert wb_rst_ni low mid-stream -> all outputs 0 immediately, FSM IDLE, STREAM read returns 0x8000.
